// File: rtl/hr_window_ctrl.sv
// Heart-rate measurement window sequencer: gated 1 s prescaler, beat edge counter,
// and conversion of the windowed count to beats-per-minute on a valid/ack handshake.
module hr_window_ctrl #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned WINDOW_S = 15,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned BPM_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             beat,
  output logic             tick_1hz,
  output logic             busy,
  output logic [7:0]       sec_left,
  output logic [BPM_W-1:0] bpm,
  output logic             bpm_valid,
  input  logic             bpm_ack,
  output logic             overflow
);

  localparam int unsigned PRE_W  = $clog2(TICK_DIV);
  localparam int unsigned MULT   = 60 / WINDOW_S;
  localparam int unsigned PROD_W = CNT_W + 7;
  localparam int unsigned SAT_W  = (PROD_W > BPM_W) ? PROD_W : BPM_W;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [BPM_W-1:0] BPM_MAX  = '1;
  localparam logic [7:0]       SEC_INIT = 8'(WINDOW_S);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2,
    S_REPORT  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PRE_W-1:0]   prescaler_q, prescaler_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               beat_q, beat_d;
  logic               tick_q, tick_d;
  logic               busy_q, busy_d;
  logic [7:0]         sec_left_q, sec_left_d;
  logic [BPM_W-1:0]   bpm_q, bpm_d;
  logic               bpm_valid_q, bpm_valid_d;
  logic               overflow_q, overflow_d;

  logic               beat_edge_c;
  logic               tick_now_c;
  logic               final_tick_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic [PROD_W-1:0]  prod_c;
  logic [SAT_W-1:0]   prod_wide_c;
  logic [BPM_W-1:0]   bpm_sat_c;

  // Event decode; the final count includes an edge landing on the last tick.
  always_comb begin
    beat_edge_c  = beat & ~beat_q;
    tick_now_c   = (state_q == S_MEASURE) && (prescaler_q == PRE_LAST);
    final_tick_c = tick_now_c && (sec_left_q == 8'd1);
    cnt_inc_c    = (beat_edge_c && (beat_cnt_q != CNT_MAX)) ? beat_cnt_q + CNT_W'(1)
                                                             : beat_cnt_q;
    prod_c       = PROD_W'(cnt_inc_c) * PROD_W'(MULT);
    prod_wide_c  = SAT_W'(prod_c);
    bpm_sat_c    = (prod_wide_c > SAT_W'(BPM_MAX)) ? BPM_MAX : BPM_W'(prod_wide_c);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks tick handling, start is seen only in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_ARM;
      S_ARM:     state_d = abort ? S_IDLE : S_MEASURE;
      S_MEASURE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (final_tick_c) begin
          state_d = S_REPORT;
        end
      end
      S_REPORT:  if (bpm_ack) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    prescaler_d = '0;
    beat_cnt_d  = beat_cnt_q;
    beat_d      = beat;
    sec_left_d  = sec_left_q;
    bpm_d       = bpm_q;
    overflow_d  = overflow_q;
    busy_d      = (state_d == S_ARM) || (state_d == S_MEASURE);
    bpm_valid_d = (state_d == S_REPORT);
    tick_d      = 1'b0;

    case (state_q)
      S_ARM: begin
        if (abort) begin
          sec_left_d = '0;
        end else begin
          beat_cnt_d = '0;
          overflow_d = 1'b0;
          sec_left_d = SEC_INIT;
        end
      end
      S_MEASURE: begin
        if (abort) begin
          sec_left_d = '0;
        end else begin
          prescaler_d = tick_now_c ? '0 : prescaler_q + PRE_W'(1);
          beat_cnt_d  = cnt_inc_c;
          if (beat_edge_c && (beat_cnt_q == CNT_MAX)) begin
            overflow_d = 1'b1;
          end
          if (final_tick_c) begin
            sec_left_d = '0;
            bpm_d      = bpm_sat_c;
          end else if (tick_now_c) begin
            sec_left_d = sec_left_q - 8'd1;
          end
        end
      end
      default: ;
    endcase

    // Registered pulse lines up with the cycle in which the prescaler shows its last count.
    tick_d = (state_d == S_MEASURE) && (prescaler_d == PRE_LAST);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      beat_cnt_q  <= '0;
      beat_q      <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      sec_left_q  <= '0;
      bpm_q       <= '0;
      bpm_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      beat_cnt_q  <= beat_cnt_d;
      beat_q      <= beat_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      sec_left_q  <= sec_left_d;
      bpm_q       <= bpm_d;
      bpm_valid_q <= bpm_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign tick_1hz  = tick_q;
  assign busy      = busy_q;
  assign sec_left  = sec_left_q;
  assign bpm       = bpm_q;
  assign bpm_valid = bpm_valid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_hr_window_ctrl.sv
// Bench for hr_window_ctrl: two configurations share stimulus; a cycle-count model
// is compared every cycle, with hand-computed literals pinning latency and results.
module tb_hr_window_ctrl;

  logic clk = 1'b0;
  logic rst_n, start, abort, beat, bpm_ack;

  logic       tick_a, busy_a, valid_a, ovf_a;
  logic [7:0] sec_a;
  logic [9:0] bpm_a;
  logic       tick_b, busy_b, valid_b, ovf_b;
  logic [7:0] sec_b;
  logic [7:0] bpm_b;

  always #5 clk = ~clk;

  hr_window_ctrl #(.TICK_DIV(10), .WINDOW_S(3), .CNT_W(8), .BPM_W(10)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .beat(beat),
    .tick_1hz(tick_a), .busy(busy_a), .sec_left(sec_a), .bpm(bpm_a),
    .bpm_valid(valid_a), .bpm_ack(bpm_ack), .overflow(ovf_a)
  );

  hr_window_ctrl #(.TICK_DIV(20), .WINDOW_S(3), .CNT_W(4), .BPM_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .beat(beat),
    .tick_1hz(tick_b), .busy(busy_b), .sec_left(sec_b), .bpm(bpm_b),
    .bpm_valid(valid_b), .bpm_ack(bpm_ack), .overflow(ovf_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 arm, 2 measure, 3 report; timing from elapsed measure cycles.
  int m_t    [2] = '{10, 20};
  int m_w    [2] = '{3, 3};
  int m_cmax [2] = '{255, 15};
  int m_bmax [2] = '{1023, 255};
  int m_mode [2];
  int m_el   [2];
  int m_cnt  [2];
  int m_ovf  [2];
  int m_bpm  [2];
  int m_sec  [2];
  bit m_prev = 1'b0;
  bit m_edge = 1'b0;
  bit m_ok   = 1'b0;

  task automatic model_step(input int d);
    int done;
    int prod;
    if (!rst_n) begin
      m_mode[d] = 0; m_el[d] = 0; m_cnt[d] = 0;
      m_ovf[d]  = 0; m_bpm[d] = 0; m_sec[d] = 0;
      return;
    end
    case (m_mode[d])
      0: if (start) m_mode[d] = 1;
      1: begin
        if (abort) begin
          m_mode[d] = 0; m_sec[d] = 0;
        end else begin
          m_cnt[d] = 0; m_ovf[d] = 0; m_sec[d] = m_w[d]; m_el[d] = 0; m_mode[d] = 2;
        end
      end
      2: begin
        if (abort) begin
          m_mode[d] = 0; m_sec[d] = 0;
        end else begin
          if (m_edge) begin
            if (m_cnt[d] == m_cmax[d]) m_ovf[d] = 1;
            else m_cnt[d] = m_cnt[d] + 1;
          end
          if (m_el[d] % m_t[d] == m_t[d] - 1) begin
            done     = m_el[d] / m_t[d] + 1;
            m_sec[d] = m_w[d] - done;
            if (done == m_w[d]) begin
              prod      = m_cnt[d] * (60 / m_w[d]);
              m_bpm[d]  = (prod > m_bmax[d]) ? m_bmax[d] : prod;
              m_mode[d] = 3;
            end
          end
          m_el[d] = m_el[d] + 1;
        end
      end
      default: if (bpm_ack) m_mode[d] = 0;
    endcase
  endtask

  always @(posedge clk) begin
    m_edge = beat && !m_prev;
    m_prev = rst_n ? beat : 1'b0;
    if (!rst_n) m_ok = 1'b1;
    for (int d = 0; d < 2; d++) model_step(d);
  end

  function automatic logic e_tick(input int d);
    return (m_mode[d] == 2) && (m_el[d] % m_t[d] == m_t[d] - 1);
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk1("a_tick",  tick_a,  e_tick(0));
      chk1("a_busy",  busy_a,  (m_mode[0] == 1) || (m_mode[0] == 2));
      chk1("a_valid", valid_a, m_mode[0] == 3);
      chkv("a_sec",   32'(sec_a), m_sec[0]);
      chkv("a_bpm",   32'(bpm_a), m_bpm[0]);
      chk1("a_ovf",   ovf_a,   m_ovf[0] != 0);
      chk1("b_tick",  tick_b,  e_tick(1));
      chk1("b_busy",  busy_b,  (m_mode[1] == 1) || (m_mode[1] == 2));
      chk1("b_valid", valid_b, m_mode[1] == 3);
      chkv("b_sec",   32'(sec_b), m_sec[1]);
      chkv("b_bpm",   32'(bpm_b), m_bpm[1]);
      chk1("b_ovf",   ovf_b,   m_ovf[1] != 0);
    end
  end

  task automatic drain();
    start = 1'b0; abort = 1'b0; beat = 1'b0; bpm_ack = 1'b1;
    repeat (70) @(negedge clk);
    bpm_ack = 1'b0;
    @(negedge clk);
  endtask

  // One full window on config A with beat pulses at the listed cycles (0 = unused).
  task automatic run_window(input int p0, input int p1, input int p2, input int p3,
                            input int exp_bpm);
    @(negedge clk);
    start = 1'b1; beat = 1'b0; abort = 1'b0; bpm_ack = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start   = 1'b0;
      beat    = (k == p0) || (k == p1) || (k == p2) || (k == p3);
      bpm_ack = (k == 35);
      chk1("lat_busy",  busy_a,  (k >= 1) && (k <= 31));
      chk1("lat_tick",  tick_a,  (k == 11) || (k == 21) || (k == 31));
      chk1("lat_valid", valid_a, (k >= 32) && (k <= 35));
      if (k >= 2) chkv("lat_sec", 32'(sec_a), (k <= 11) ? 3 : (k <= 21) ? 2 : (k <= 31) ? 1 : 0);
      if (k == 32) chkv("win_bpm", 32'(bpm_a), exp_bpm);
    end
    beat = 1'b0; bpm_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; beat = 1'b0; bpm_ack = 1'b0;

    // Reset held while beat toggles.
    @(negedge clk); beat = 1'b1;
    @(negedge clk); beat = 1'b0;
    chk1("rst_busy",  busy_a,  1'b0);
    chk1("rst_tick",  tick_a,  1'b0);
    chk1("rst_valid", valid_a, 1'b0);
    chk1("rst_ovf",   ovf_a,   1'b0);
    chkv("rst_sec",   32'(sec_a), 0);
    chkv("rst_bpm",   32'(bpm_a), 0);
    chkv("rst_bpm_b", 32'(bpm_b), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      beat = ~beat;
      chk1("idle_busy", busy_a, 1'b0);
    end
    beat = 1'b0;
    @(negedge clk);

    // Normal window: 4 beats -> 4 * 20 = 80.
    run_window(5, 9, 15, 25, 80);
    drain();

    // Abort mid-window keeps previous result and emits nothing.
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (k == 15);
      chk1("abort_busy",  busy_a,  (k >= 1) && (k <= 15));
      chk1("abort_valid", valid_a, 1'b0);
    end
    abort = 1'b0;
    chkv("abort_bpm_kept", 32'(bpm_a), 80);
    drain();
    run_window(6, 12, 0, 0, 40);
    drain();

    // Edge on the final tick cycle is counted: 3 * 20 = 60.
    run_window(10, 20, 31, 0, 60);
    drain();

    // Saturation: 20 edges; B (4-bit count) stops at 15 and clips 300 to 255.
    @(negedge clk); start = 1'b1; beat = 1'b0;
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      start   = 1'b0;
      beat    = (k >= 2) && (k <= 40) && (k % 2 == 0);
      bpm_ack = (k == 65);
      if (k == 64) begin
        chkv("sat_bpm_b", 32'(bpm_b), 255);
        chk1("sat_ovf_b", ovf_b, 1'b1);
        chk1("sat_valid_b", valid_b, 1'b1);
        chkv("sat_bpm_a", 32'(bpm_a), 300);
        chk1("sat_ovf_a", ovf_a, 1'b0);
      end
    end
    bpm_ack = 1'b0; beat = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk1("ovf_in_arm", ovf_b, 1'b1);
    @(negedge clk);
    chk1("ovf_cleared", ovf_b, 1'b0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    drain();

    // Reset during MEASURE.
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      rst_n = !(k == 10);
      if (k == 11) begin
        chk1("mid_rst_busy", busy_a, 1'b0);
        chkv("mid_rst_sec",  32'(sec_a), 0);
        chkv("mid_rst_bpm",  32'(bpm_a), 0);
      end
    end
    rst_n = 1'b1;

    // REPORT ignores start/abort; ack with start held re-arms after one IDLE cycle.
    @(negedge clk); start = 1'b1; beat = 1'b0;
    for (int k = 1; k <= 43; k++) begin
      @(negedge clk);
      start   = (k == 33) || (k == 36) || (k == 40) || (k == 41);
      abort   = (k == 34) || (k == 37);
      beat    = (k == 5);
      bpm_ack = (k == 40);
      if (k >= 33 && k <= 40) begin
        chk1("rep_valid", valid_a, 1'b1);
        chkv("rep_bpm",   32'(bpm_a), 20);
      end
      if (k == 41) begin
        chk1("ack_valid", valid_a, 1'b0);
        chk1("ack_idle",  busy_a,  1'b0);
      end
      if (k == 42 || k == 43) chk1("rearm_busy", busy_a, 1'b1);
    end
    start = 1'b0; abort = 1'b0; beat = 1'b0; bpm_ack = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hr_window_ctrl.md
Name: hr_window_ctrl

Overview:
Measurement-window sequencer for the heart-rate path. It owns a gated 1 s timebase prescaler and sequences each window as IDLE -> ARM -> MEASURE -> REPORT. During MEASURE it counts beat rising edges for WINDOW_S seconds. It then converts the count to beats-per-minute and presents the result on a valid/ack handshake to the display/UART consumer.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 s tick (>=2)
WINDOW_S, 15, window length in seconds; must divide 60 exactly (1,2,3,4,5,6,10,12,15,20,30,60)
CNT_W, 8, beat counter width
BPM_W, 10, bpm output width

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-low
start  input  1  request a measurement window; single-cycle pulse or level, sampled only in IDLE
abort  input  1  cancel the current window
beat  input  1  beat comparator level, already synchronous to clk
tick_1hz  output  1  one-cycle pulse per elapsed second, MEASURE only
busy  output  1  high in ARM and MEASURE
sec_left  output  8  seconds remaining in window
bpm  output  BPM_W  last completed result
bpm_valid  output  1  result handshake valid
bpm_ack  input  1  consumer accepts result
overflow  output  1  beat counter saturated in last or current window

Behaviour:
- Reset values (rst_n low at a clk edge): state=IDLE; prescaler, beat_cnt, beat_q, tick_1hz, busy, sec_left, bpm, bpm_valid and overflow all 0.
- beat_q registers beat every cycle in every state. An edge is beat & ~beat_q. Edges are counted only in MEASURE.
- IDLE: prescaler held at 0. start=1 -> ARM. abort is ignored.
- ARM (exactly 1 cycle): clear beat_cnt and overflow, load sec_left=WINDOW_S, clear prescaler, busy=1 -> MEASURE.
- MEASURE:
  - Prescaler counts 0..TICK_DIV-1 and wraps. tick_1hz=1 in the cycle where prescaler==TICK_DIV-1; the first tick occurs TICK_DIV cycles after MEASURE entry.
  - Edge: beat_cnt += 1, saturating at 2^CNT_W-1. Overflow sets when an edge arrives at saturation and is sticky until the next ARM.
  - Tick with sec_left>1: sec_left -= 1.
  - Tick with sec_left==1: sec_left=0, latch bpm = final_cnt * (60/WINDOW_S) saturated to 2^BPM_W-1, -> REPORT.
  - An edge in the same cycle as the final tick is included in final_cnt.
- REPORT:
  - busy=0, bpm_valid=1; bpm is stable while valid.
  - bpm_ack=1 -> bpm_valid=0 next cycle -> IDLE.
  - bpm_ack is ignored outside REPORT. start is ignored in REPORT.
- abort: in ARM/MEASURE -> IDLE next cycle; busy=0, prescaler=0, bpm and bpm_valid unchanged (no result emitted). In REPORT, abort is ignored; only bpm_ack leaves REPORT.
- Priority in any cycle: rst_n > abort > tick/edge processing > start.
- Latency:
  - start sampled in IDLE at cycle N -> busy=1 at N+1.
  - MEASURE entered at N+2.
  - Final tick at N+1+WINDOW_S*TICK_DIV.
  - bpm_valid=1 at N+2+WINDOW_S*TICK_DIV.
- Multiply is by a constant (60/WINDOW_S), computed in the width CNT_W+7 before saturation. No dividers.
- Back-to-back windows: start held high re-arms on the cycle after ack returns the block to IDLE.

Test Plan:
1. Reset: rst_n=0 for 2 cycles while beat toggles -> every output 0, busy=0, no tick_1hz; beat edges after release in IDLE do not change the count.
2. Normal window (TICK_DIV=10, WINDOW_S=3): start pulse at cycle 0, 4 clean beat pulses inside window -> busy=1 cycles 1..31, tick_1hz at cycles 11/21/31, sec_left 3->2->1->0, bpm_valid=1 at cycle 32 with bpm=80; holds until bpm_ack, then IDLE.
3. Boundary edge: same config, 2 beats mid-window plus a beat edge exactly on the cycle-31 final tick -> bpm=60 (3*20).
4. Saturation (CNT_W=4, BPM_W=8, WINDOW_S=3): 20 edges -> beat_cnt stops at 15, overflow=1, bpm=255 (300 saturated); next start clears overflow in ARM.
5. Abort: start, then abort at cycle 15 -> IDLE at 16, busy=0, bpm_valid never rises, bpm keeps prior value 80; new start yields correct fresh result.
6. Reset mid-op and REPORT rules: rst_n low during MEASURE -> IDLE, sec_left=0; in REPORT, start/abort pulses without ack keep bpm_valid=1 and bpm stable; ack with start high -> new window begins.
